// File: rtl/muc_arbiter.sv
// muc_arbiter: round-robin front end that shares one registered sign-magnitude
// multiplier among NREQ requesters and returns requester-tagged products in
// grant order, one per cycle, with a fixed latency of MUL_LAT+2 edges.
// Optional feature: define MUC_ARB_CNT_EN to add per-requester saturating
// 8-bit grant counters on the grant_cnt port.
module muc_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned W       = 2,
    parameter int unsigned MUL_LAT = 1,
    parameter int unsigned TAGW    = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_asign,
    input  logic [NREQ-1:0]   req_bsign,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    output logic              mul_asign,
    output logic              mul_bsign,
    input  logic [2*W-1:0]    mul_p,
    input  logic              mul_sign,
    output logic              rsp_valid,
    output logic [TAGW-1:0]   rsp_id,
    output logic [2*W-1:0]    rsp_p,
    output logic              rsp_sign
`ifdef MUC_ARB_CNT_EN
    ,
    output logic [NREQ*8-1:0] grant_cnt
`endif
);

    localparam int unsigned PW   = 2 * W;
    localparam int unsigned TW1  = TAGW + 1;
    localparam int unsigned CNTW = 8;

    // Round-robin pointer: the first index searched on the next cycle.
    logic [TAGW-1:0] rr_ptr;
    logic [TAGW-1:0] rr_ptr_nxt;

    // Arbitration results.
    logic            found;
    logic            hs;
    logic [TAGW-1:0] gnt_idx;
    logic [TW1-1:0]  scan_sum;
    logic [TAGW-1:0] scan_idx;

    // Operands of the granted lane.
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;
    logic            sel_asign;
    logic            sel_bsign;

    // Issue stage: valid/tag that travel alongside the multiplier inputs.
    logic            issue_v;
    logic [TAGW-1:0] issue_tag;

    // Tag/valid delay line matching the multiplier latency.
    logic            pipe_v   [MUL_LAT];
    logic [TAGW-1:0] pipe_tag [MUL_LAT];

    // Product is zero: suppresses a negative sign on zero results.
    logic            prod_zero;

    // Scan rr_ptr, rr_ptr+1, ... (mod NREQ) and pick the first valid requester.
    always_comb begin
        found    = 1'b0;
        gnt_idx  = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + TW1'(k);
            if (scan_sum >= TW1'(NREQ)) begin
                scan_sum = scan_sum - TW1'(NREQ);
            end
            scan_idx = TAGW'(scan_sum);
            if (!found && req_valid[scan_idx]) begin
                found   = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

    // A handshake happens whenever something is granted; nothing is granted in reset.
    assign hs = found & rst_n;

    // One-hot ready toward the granted requester.
    always_comb begin
        req_ready = '0;
        if (hs) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Next pointer: one past the granted index, wrapping at NREQ.
    always_comb begin
        rr_ptr_nxt = rr_ptr;
        if (hs) begin
            if (gnt_idx == TAGW'(NREQ - 1)) begin
                rr_ptr_nxt = '0;
            end else begin
                rr_ptr_nxt = gnt_idx + TAGW'(1);
            end
        end
    end

    // Operand mux for the granted lane.
    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        sel_asign = 1'b0;
        sel_bsign = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_idx == TAGW'(i)) begin
                sel_a     = req_a[i*W +: W];
                sel_b     = req_b[i*W +: W];
                sel_asign = req_asign[i];
                sel_bsign = req_bsign[i];
            end
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= rr_ptr_nxt;
        end
    end

    // Issue registers; multiplier inputs only move on a handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a     <= '0;
            mul_b     <= '0;
            mul_asign <= 1'b0;
            mul_bsign <= 1'b0;
            issue_v   <= 1'b0;
            issue_tag <= '0;
        end else begin
            issue_v <= hs;
            if (hs) begin
                mul_a     <= sel_a;
                mul_b     <= sel_b;
                mul_asign <= sel_asign;
                mul_bsign <= sel_bsign;
                issue_tag <= gnt_idx;
            end
        end
    end

    // Tag/valid shift register running in step with the multiplier pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < MUL_LAT; i++) begin
                pipe_v[i]   <= 1'b0;
                pipe_tag[i] <= '0;
            end
        end else begin
            pipe_v[0]   <= issue_v;
            pipe_tag[0] <= issue_tag;
            for (int unsigned i = 1; i < MUL_LAT; i++) begin
                pipe_v[i]   <= pipe_v[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
        end
    end

    assign prod_zero = (mul_p == PW'(0));

    // Response capture at the tail of the delay line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_p     <= '0;
            rsp_sign  <= 1'b0;
        end else begin
            rsp_valid <= pipe_v[MUL_LAT-1];
            if (pipe_v[MUL_LAT-1]) begin
                rsp_id   <= pipe_tag[MUL_LAT-1];
                rsp_p    <= mul_p;
                rsp_sign <= mul_sign & ~prod_zero;
            end
        end
    end

`ifdef MUC_ARB_CNT_EN
    logic [CNTW-1:0] cnt_q [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_cnt
        // Saturating count of handshakes granted to requester g.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q[g] <= '0;
            end else if (hs && (gnt_idx == TAGW'(g)) && (cnt_q[g] != {CNTW{1'b1}})) begin
                cnt_q[g] <= cnt_q[g] + CNTW'(1);
            end
        end

        assign grant_cnt[g*CNTW +: CNTW] = cnt_q[g];
    end
`endif

endmodule
